im2col_fetch: RTL



---
 rtl/im2col_pkg.sv | 17 +
 rtl/im2col_skid_fifo.sv | 33 +++
 rtl/im2col_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/im2col_pkg.sv
// im2col_pkg: shared FSM encoding, skid FIFO depth and FIFO word tag layout for im2col_fetch
package im2col_pkg;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CHECK = 5'b00010,
    RUN   = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } state_t;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // FIFO word is {frame_last, col_last, data}
  localparam int TAG_W = 2;
  function automatic logic [TAG_W-1:0] mk_tag(input logic fl, input logic cl);
    return {fl, cl};
  endfunction
endpackage

// File: rtl/im2col_skid_fifo.sv
// im2col_skid_fifo: FIFO_DEPTH-entry skid FIFO with occupancy count
module im2col_skid_fifo
  import im2col_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
endmodule

// File: rtl/im2col_fetch.sv
// im2col_fetch: im2col address generator and patch streamer over the ifmap read port.
// Optional one-pixel zero padding is built when IM2COL_PAD_EN is defined.
module im2col_fetch
  import im2col_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 12,
  parameter int DIM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_h,
  input  logic [DIM_W-1:0]      cfg_w,
  input  logic [DIM_W-1:0]      cfg_c,
  input  logic [DIM_W-1:0]      cfg_k,
  input  logic [DIM_W-1:0]      cfg_s,
`ifdef IM2COL_PAD_EN
  input  logic                  cfg_pad,
`endif
  output logic [ADDR_SIZE-1:0]  tensor_addr,
  output logic                  t_addr_vld,
  input  logic [DATA_WIDTH-1:0] tensor_data,
  output logic [DATA_WIDTH-1:0] col_data,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic                  col_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int EW = DIM_W + 2;
  localparam int FW = DATA_WIDTH + TAG_W;
  state_t state, state_n;
  logic [DIM_W-1:0] h, w, c, k, s, kx, ky, ci;
  logic [EW-1:0] he, we, oh, ow, ox, oy, oh_n, ow_n, s_div;
  logic [ADDR_SIZE-1:0] cur, row, chan, patch, line, hw, sw, wa, sa, base0;
  logic [ADDR_SIZE-1:0] row_n, chan_n, patch_n, line_n, p_nx, ch_nx, r_nx, cur_nx;
  logic [TAG_W-1:0] tag_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] occ;
  logic [FW-1:0] head;
  logic [DATA_WIDTH-1:0] push_data;
  logic inflight, pop, issue, oob, cfg_bad, lx, ly, lc, lox, loy, c1, c2, c3, last_el;
`ifdef IM2COL_PAD_EN
  logic pad, zero_d;
  logic [EW-1:0] oys, oxs, iy, ix;
  assign he = EW'(h) + (pad ? EW'(2) : EW'(0));
  assign we = EW'(w) + (pad ? EW'(2) : EW'(0));
  assign base0 = pad ? ~ADDR_SIZE'(w) : '0;
  assign iy = oys + EW'(ky);
  assign ix = oxs + EW'(kx);
  // padded coordinates: row/col 0 and H+1/W+1 are the zero border
  assign oob = pad && (iy == '0 || ix == '0 || iy > EW'(h) || ix > EW'(w));
  assign push_data = zero_d ? '0 : tensor_data;
`else
  assign he = EW'(h);
  assign we = EW'(w);
  assign base0 = '0;
  assign oob = 1'b0;
  assign push_data = tensor_data;
`endif
  assign cfg_bad = k == '0 || s == '0 || c == '0 || EW'(k) > he || EW'(k) > we;
  assign s_div = (s == '0) ? EW'(1) : EW'(s);
  assign oh_n = (he - EW'(k)) / s_div + EW'(1);
  assign ow_n = (we - EW'(k)) / s_div + EW'(1);
  assign lx = kx == k - DIM_W'(1);
  assign ly = ky == k - DIM_W'(1);
  assign lc = ci == c - DIM_W'(1);
  assign lox = ox == ow - EW'(1);
  assign loy = oy == oh - EW'(1);
  assign c1 = lx & ly;
  assign c2 = c1 & lc;
  assign c3 = c2 & lox;
  assign last_el = c3 & loy;
  assign row_n = row + wa;
  assign chan_n = chan + hw;
  assign patch_n = patch + sa;
  assign line_n = line + sw;
  assign p_nx = c3 ? line_n : patch_n;
  assign ch_nx = c2 ? p_nx : chan_n;
  assign r_nx = c1 ? ch_nx : row_n;
  assign cur_nx = lx ? r_nx : cur + ADDR_SIZE'(1);
  assign col_valid = cnt != '0;
  assign pop = col_valid & col_ready;
  // the same-cycle pop frees a slot, which sustains one element per cycle
  assign occ = (CNT_W+1)'(cnt) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue = state == RUN && occ < (CNT_W+1)'(FIFO_DEPTH);
  assign t_addr_vld = issue & ~oob;
  assign tensor_addr = cur;
  assign {frame_last, col_last, col_data} = head;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CHECK;
      CHECK:   state_n = cfg_bad ? DONE : RUN;
      RUN:     if (issue && last_el) state_n = DRAIN;
      DRAIN:   if (cnt == '0 && !inflight) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {h, w, c, k, s, kx, ky, ci} <= '0;
      {oh, ow, ox, oy} <= '0;
      {cur, row, chan, patch, line, hw, sw, wa, sa} <= '0;
      tag_d <= '0;
      inflight <= 1'b0;
      cfg_err <= 1'b0;
`ifdef IM2COL_PAD_EN
      {pad, zero_d} <= '0;
      {oys, oxs} <= '0;
`endif
    end else begin
      state <= state_n;
      inflight <= issue;
      tag_d <= mk_tag(last_el, c2);
`ifdef IM2COL_PAD_EN
      zero_d <= oob;
`endif
      if (state == IDLE && start) begin
        {h, w, c, k, s} <= {cfg_h, cfg_w, cfg_c, cfg_k, cfg_s};
        cfg_err <= 1'b0;
`ifdef IM2COL_PAD_EN
        pad <= cfg_pad;
`endif
      end
      if (state == CHECK) begin
        cfg_err <= cfg_bad;
        oh <= oh_n;
        ow <= ow_n;
        hw <= ADDR_SIZE'(h) * ADDR_SIZE'(w);
        sw <= ADDR_SIZE'(s) * ADDR_SIZE'(w);
        wa <= ADDR_SIZE'(w);
        sa <= ADDR_SIZE'(s);
        {kx, ky, ci} <= '0;
        {ox, oy} <= '0;
        {cur, row, chan, patch, line} <= {5{base0}};
`ifdef IM2COL_PAD_EN
        {oys, oxs} <= '0;
`endif
      end
      if (issue) begin
        cur <= cur_nx;
        kx <= lx ? '0 : kx + DIM_W'(1);
        if (lx) begin
          row <= r_nx;
          ky <= ly ? '0 : ky + DIM_W'(1);
        end
        if (c1) begin
          chan <= ch_nx;
          ci <= lc ? '0 : ci + DIM_W'(1);
        end
        if (c2) begin
          patch <= p_nx;
          ox <= lox ? '0 : ox + EW'(1);
`ifdef IM2COL_PAD_EN
          oxs <= lox ? '0 : oxs + EW'(s);
`endif
        end
        if (c3) begin
          line <= line_n;
          oy <= oy + EW'(1);
`ifdef IM2COL_PAD_EN
          oys <= oys + EW'(s);
`endif
        end
      end
    end
  im2col_skid_fifo #(.WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({tag_d, push_data}),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );
endmodule
